// File: rtl/pc_sequencer_if.sv
// Interface for the pc_sequencer control/memory/datapath signals.
//   slave  : the pc_sequencer itself. It receives en, sel, mdb, calc_out,
//            mem_rdy, irq_req and irq_vec, and drives pc_out, vec_rd,
//            vec_addr, irq_ack, ret_pc and busy.
//   master : the control unit, datapath and memory side (opposite directions).
// WIDTH must match the WIDTH of the pc_sequencer that is connected.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             en;
  logic [2:0]       sel;
  logic [WIDTH-1:0] mdb;
  logic [WIDTH-1:0] calc_out;
  logic             mem_rdy;
  logic             irq_req;
  logic [WIDTH-1:0] irq_vec;
  logic [WIDTH-1:0] pc_out;
  logic             vec_rd;
  logic [WIDTH-1:0] vec_addr;
  logic             irq_ack;
  logic [WIDTH-1:0] ret_pc;
  logic             busy;

  modport slave (
    input  en, sel, mdb, calc_out, mem_rdy, irq_req, irq_vec,
    output pc_out, vec_rd, vec_addr, irq_ack, ret_pc, busy
  );

  modport master (
    output en, sel, mdb, calc_out, mem_rdy, irq_req, irq_vec,
    input  pc_out, vec_rd, vec_addr, irq_ack, ret_pc, busy
  );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with a five-source next-PC select, a boot-time
// reset-vector fetch and an interrupt-vector fetch handshake.
// Ports:
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous active-high reset (returns to the reset-vector fetch)
//   bus  : pc_sequencer_if.slave
//          inputs  en, sel, mdb, calc_out, mem_rdy, irq_req, irq_vec
//          outputs pc_out, vec_rd, vec_addr, irq_ack, ret_pc, busy
// sel: 0 = pc+INC, 1 = hold, 2 = calc_out, 3 = mdb<<1, 4 = mdb, 5-7 = hold.
module pc_sequencer #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      INC       = 2,
  parameter int unsigned      ALIGN     = 1,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(16'hFFFE)
) (
  input logic             clk,
  input logic             rst,
  pc_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    RST_FETCH,
    RUN,
    IRQ_FETCH
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] pc, pc_d;
  logic [WIDTH-1:0] ret, ret_d;
  logic [WIDTH-1:0] ivec, ivec_d;
  logic             ack, ack_d;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] mux;

  // Every value loaded into the PC goes through this when ALIGN is set.
  function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
    if (ALIGN != 0) r[0] = 1'b0;
    return r;
  endfunction

  assign next_pc = align(pc) + WIDTH'(INC);

  always_comb begin
    mux = pc;
    case (bus.sel)
      3'd0:    mux = next_pc;
      3'd2:    mux = bus.calc_out;
      3'd3:    mux = {bus.mdb[WIDTH-2:0], 1'b0};
      3'd4:    mux = bus.mdb;
      default: mux = pc;
    endcase
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    ret_d   = ret;
    ivec_d  = ivec;
    ack_d   = 1'b0;
    case (state)
      RST_FETCH, IRQ_FETCH: begin
        if (bus.mem_rdy) begin
          pc_d    = align(bus.mdb);
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.en) begin
          // Interrupt wins over the simultaneous load; the target it would
          // have loaded becomes the return address instead.
          if (bus.irq_req) begin
            ret_d   = align(mux);
            ivec_d  = bus.irq_vec;
            ack_d   = 1'b1;
            state_d = IRQ_FETCH;
          end else begin
            pc_d = align(mux);
          end
        end
      end
      default: state_d = RST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_FETCH;
      pc    <= '0;
      ret   <= '0;
      ivec  <= '0;
      ack   <= 1'b0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      ret   <= ret_d;
      ivec  <= ivec_d;
      ack   <= ack_d;
    end
  end

  assign bus.pc_out   = pc;
  assign bus.ret_pc   = ret;
  assign bus.irq_ack  = ack;
  assign bus.vec_rd   = (state != RUN);
  assign bus.busy     = (state != RUN);
  assign bus.vec_addr = (state == IRQ_FETCH) ? ivec : RESET_VEC;

endmodule
